// File: rtl/cache_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : cache_write_buffer
// Brief    : Posted-write FIFO between the D-cache memory port and main memory.
//            Writes are acked on entry and drained in order; reads are ordered
//            against buffered writes. Define WB_READ_BYPASS_EN to let reads
//            that hit no buffered word overtake the FIFO.
// Revision : 1.0  initial release
// ============================================================================
module cache_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              up_addr_i,
    input  logic [31:0]              up_wdata_i,
    input  logic                     up_we_i,
    input  logic [3:0]               up_be_i,
    input  logic                     up_req_i,
    output logic                     up_gnt_o,
    output logic                     up_rvalid_o,
    output logic [31:0]              up_rdata_o,
    output logic                     up_error_o,
    output logic [31:0]              mem_addr_o,
    output logic [31:0]              mem_wdata_o,
    output logic                     mem_we_o,
    output logic [3:0]               mem_be_o,
    output logic                     mem_req_o,
    input  logic                     mem_gnt_i,
    input  logic                     mem_rvalid_i,
    input  logic                     mem_error_i,
    input  logic [31:0]              mem_rdata_i,
    output logic [$clog2(DEPTH):0]   wb_count_o,
    output logic                     wb_write_err_o
);

    localparam int              c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_full = (c_aw + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_WAIT = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_WAIT = 3'd4
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [31:0]       r_addr  [DEPTH];
    logic [31:0]       r_wdata [DEPTH];
    logic [3:0]        r_be    [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_aw:0]     r_count;
    logic              r_rd_pending;
    logic [31:0]       r_rd_addr;
    logic              r_wr_ack, r_rd_ack;
    logic [31:0]       r_rdata;
    logic              r_rerr;
    logic              r_wb_err;

    logic w_full, w_empty, w_push, w_pop, w_rd_accept, w_rd_done, w_read_allowed;

    assign w_full      = (r_count == c_full);
    assign w_empty     = (r_count == '0);
    assign up_gnt_o    = up_req_i & ~r_rd_pending & (up_we_i ? ~w_full : 1'b1);
    assign w_push      = up_gnt_o & up_we_i;
    assign w_rd_accept = up_gnt_o & ~up_we_i;

`ifdef WB_READ_BYPASS_EN
    // A read arriving this cycle is checked against its live address so the
    // IDLE decision can be made in the grant cycle.
    logic [31:0]      w_cmp_addr;
    logic [DEPTH-1:0] w_hit;
    assign w_cmp_addr = r_rd_pending ? r_rd_addr : up_addr_i;
    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        logic [c_aw-1:0] w_off;
        assign w_off    = c_aw'(i) - r_rd_ptr;
        assign w_hit[i] = ({1'b0, w_off} < r_count) &&
                          (r_addr[i][31:2] == w_cmp_addr[31:2]);
    end
    assign w_read_allowed = w_empty | ~(|w_hit);
`else
    assign w_read_allowed = w_empty;
`endif

    always_comb begin
        w_state_nxt = r_state;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        w_pop       = 1'b0;
        w_rd_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_rd_pending | w_rd_accept) & w_read_allowed)
                    w_state_nxt = S_RD_REQ;
                else if (!w_empty)
                    w_state_nxt = S_WR_REQ;
            end
            S_WR_REQ: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = r_addr[r_rd_ptr];
                mem_wdata_o = r_wdata[r_rd_ptr];
                mem_be_o    = r_be[r_rd_ptr];
                if (mem_gnt_i) w_state_nxt = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (mem_rvalid_i) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = r_rd_addr;
                mem_be_o   = 4'b1111;
                if (mem_gnt_i) w_state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (mem_rvalid_i) begin
                    w_rd_done   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Storage needs no reset: only pointers/count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr]  <= up_addr_i;
            r_wdata[r_wr_ptr] <= up_wdata_i;
            r_be[r_wr_ptr]    <= up_be_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_rd_pending <= 1'b0;
            r_rd_addr    <= '0;
            r_wr_ack     <= 1'b0;
            r_rd_ack     <= 1'b0;
            r_rdata      <= '0;
            r_rerr       <= 1'b0;
            r_wb_err     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ack <= w_push;
            r_rd_ack <= w_rd_done;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
            if (w_rd_accept) begin
                r_rd_pending <= 1'b1;
                r_rd_addr    <= up_addr_i;
            end else if (w_rd_done) begin
                r_rd_pending <= 1'b0;
            end
            if (w_rd_done) begin
                r_rdata <= mem_rdata_i;
                r_rerr  <= mem_error_i;
            end
            if (w_pop && mem_error_i) r_wb_err <= 1'b1;
        end
    end

    assign up_rvalid_o    = r_wr_ack | r_rd_ack;
    assign up_rdata_o     = r_rd_ack ? r_rdata : '0;
    assign up_error_o     = r_rd_ack & r_rerr;
    assign wb_count_o     = r_count;
    assign wb_write_err_o = r_wb_err;

endmodule
`default_nettype wire
